// File: rtl/run_controller.sv
// -----------------------------------------------------------------------------
// run_controller
//
// Run/observation controller for the 4-bit CPU system. It sequences the CPU
// reset, gates CPU execution with a clock enable, counts RUN clocks and
// completed instruction cycles, and ends a run on an instruction budget, an
// abort request, or (optionally) halt detection. On entry to DONE it freezes a
// snapshot of the CPU PC, accumulator and carry for readout.
//
// Optional feature macro: RUN_CONTROLLER_HALT_DETECT_EN
//   Defined   : a jump-to-self halt is detected when HALT_REPEAT consecutive
//               instruction-boundary PC samples are identical.
//   Undefined : no comparator or repeat counter; halted is held at 0.
//
// Ports:
//   clock        in   system clock
//   reset        in   synchronous, active-high reset
//   start        in   begin a run (sampled in IDLE or DONE only)
//   abort        in   end the run early (effective in RESET_HOLD or RUN)
//   pc           in   CPU program counter
//   accumulator  in   CPU accumulator
//   carry        in   CPU carry flag
//   cpu_reset    out  reset to the CPU
//   cpu_enable   out  CPU clock enable, high only in RUN
//   phase        out  position within the current instruction cycle
//   cycle_count  out  RUN clocks elapsed (saturating)
//   instr_count  out  instruction cycles completed
//   done         out  run finished, snapshot valid
//   halted       out  run ended by halt detection
//   aborted      out  run ended by abort
//   snap_pc      out  captured PC
//   snap_acc     out  captured accumulator
//   snap_carry   out  captured carry
//
// All outputs are registered. The current FSM state is visible on the
// internal signal 'state' (type state_t) for hierarchical observation.
// -----------------------------------------------------------------------------
module run_controller #(
    parameter int RESET_CYCLES     = 2,
    parameter int CLOCKS_PER_INSTR = 8,
    parameter int MAX_INSTR        = 256,
    parameter int COUNT_WIDTH      = 32,
    parameter int PC_WIDTH         = 12,
    parameter int HALT_REPEAT      = 4
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [PC_WIDTH-1:0]                   pc,
    input  logic [3:0]                            accumulator,
    input  logic                                  carry,
    output logic                                  cpu_reset,
    output logic                                  cpu_enable,
    output logic [$clog2(CLOCKS_PER_INSTR)-1:0]   phase,
    output logic [COUNT_WIDTH-1:0]                cycle_count,
    output logic [COUNT_WIDTH-1:0]                instr_count,
    output logic                                  done,
    output logic                                  halted,
    output logic                                  aborted,
    output logic [PC_WIDTH-1:0]                   snap_pc,
    output logic [3:0]                            snap_acc,
    output logic                                  snap_carry
);

    localparam int PHASE_W = $clog2(CLOCKS_PER_INSTR);
    localparam int HOLD_W  = $clog2(RESET_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RESET_HOLD = 2'd1,
        RUN        = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [HOLD_W-1:0]      hold_count;
    logic [COUNT_WIDTH-1:0] instr_next;

    logic start_run;    // accepted start request
    logic abort_run;    // abort in a state where it is honoured
    logic hold_done;    // last RESET_HOLD clock
    logic boundary;     // final clock of an instruction cycle while running
    logic budget_hit;   // this boundary completes the MAX_INSTR-th instruction
    logic halt_hit;     // halt detector fires on this boundary
    logic enter_done;   // edge on which the run terminates

    logic cpu_reset_next;
    logic cpu_enable_next;
    logic done_next;

    // -------------------------------------------------------------------------
    // Shared decode
    // -------------------------------------------------------------------------
    assign start_run  = start && ((state == IDLE) || (state == DONE));
    assign abort_run  = abort && ((state == RESET_HOLD) || (state == RUN));
    assign hold_done  = (hold_count == HOLD_W'(RESET_CYCLES - 1));
    assign boundary   = (state == RUN) && (phase == PHASE_W'(CLOCKS_PER_INSTR - 1));
    assign instr_next = instr_count + COUNT_WIDTH'(1);
    assign budget_hit = boundary && (instr_next == COUNT_WIDTH'(MAX_INSTR));

`ifdef RUN_CONTROLLER_HALT_DETECT_EN
    // -------------------------------------------------------------------------
    // Halt detection: a CPU spinning on a jump-to-self presents the same PC at
    // every instruction boundary. repeat_count == 0 marks "no sample yet this
    // run", so the first boundary always loads 1.
    // -------------------------------------------------------------------------
    localparam int REP_W = $clog2(HALT_REPEAT + 1);

    logic [PC_WIDTH-1:0] prev_pc;
    logic [REP_W-1:0]    repeat_count;
    logic [REP_W-1:0]    repeat_next;

    always_comb begin
        repeat_next = REP_W'(1);
        if ((repeat_count != '0) && (pc == prev_pc)) begin
            if (repeat_count == REP_W'(HALT_REPEAT)) begin
                repeat_next = repeat_count;
            end else begin
                repeat_next = repeat_count + REP_W'(1);
            end
        end
    end

    assign halt_hit = boundary && (repeat_next == REP_W'(HALT_REPEAT));

    always_ff @(posedge clock) begin
        if (reset || start_run) begin
            prev_pc      <= '0;
            repeat_count <= '0;
        end else if (boundary && !abort) begin
            prev_pc      <= pc;
            repeat_count <= repeat_next;
        end
    end
`else
    assign halt_hit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic (abort has priority over halt and budget)
    // -------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) next_state = RESET_HOLD;
            end
            RESET_HOLD: begin
                if (abort)          next_state = DONE;
                else if (hold_done) next_state = RUN;
            end
            RUN: begin
                if (abort || halt_hit || budget_hit) next_state = DONE;
            end
            DONE: begin
                if (start) next_state = RESET_HOLD;
            end
            default: next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output logic. Outputs are decoded from next_state and registered so
    // that cpu_reset/cpu_enable/done change on the same edge as the state.
    // -------------------------------------------------------------------------
    always_comb begin
        cpu_reset_next  = 1'b0;
        cpu_enable_next = 1'b0;
        done_next       = 1'b0;
        case (next_state)
            IDLE:       cpu_reset_next  = 1'b1;
            RESET_HOLD: cpu_reset_next  = 1'b1;
            RUN:        cpu_enable_next = 1'b1;
            DONE:       done_next       = 1'b1;
            default:    cpu_reset_next  = 1'b1;
        endcase
    end

    assign enter_done = (next_state == DONE) && (state != DONE);

    // -------------------------------------------------------------------------
    // Registered outputs and datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_reset   <= 1'b1;
            cpu_enable  <= 1'b0;
            done        <= 1'b0;
            phase       <= '0;
            cycle_count <= '0;
            instr_count <= '0;
            hold_count  <= '0;
            halted      <= 1'b0;
            aborted     <= 1'b0;
            snap_pc     <= '0;
            snap_acc    <= '0;
            snap_carry  <= 1'b0;
        end else begin
            cpu_reset  <= cpu_reset_next;
            cpu_enable <= cpu_enable_next;
            done       <= done_next;

            if (start_run) begin
                phase       <= '0;
                cycle_count <= '0;
                instr_count <= '0;
                hold_count  <= '0;
                halted      <= 1'b0;
                aborted     <= 1'b0;
            end else begin
                if ((state == RESET_HOLD) && !abort && !hold_done) begin
                    hold_count <= hold_count + HOLD_W'(1);
                end

                // An abort edge freezes the counters at their pre-abort values.
                if ((state == RUN) && !abort) begin
                    if (!(&cycle_count)) begin
                        cycle_count <= cycle_count + COUNT_WIDTH'(1);
                    end
                    if (boundary) begin
                        phase       <= '0;
                        instr_count <= instr_next;
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end

                if (enter_done) begin
                    snap_pc    <= pc;
                    snap_acc   <= accumulator;
                    snap_carry <= carry;
                    aborted    <= abort_run;
                    halted     <= !abort_run && halt_hit;
                end
            end
        end
    end

endmodule
